keypad_scan_buffer: RTL and testbench

KEYPAD_SCAN_BUFFER -- requirements
Module: keypad_scan_buffer

---
 rtl/keypad_pkg.sv | 55 +++++
 rtl/key_fifo.sv | 58 +++++
 rtl/keypad_scan_buffer.sv | 219 +++++++++++++++++++++
 tb/tb_keypad_scan_buffer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: FSM states, operator codes and the
// 4x4 calculator-pad decode.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PUSH,
    ST_RELEASE
  } scan_state_e;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_NEG  = 3'd4,
    OP_CLR  = 3'd5
  } op_code_e;

  typedef struct packed {
    logic [3:0] digit;
    op_code_e   op;
    logic       equal;
  } key_decode_t;

  // Code = row*4 + col on the standard calculator layout.
  function automatic key_decode_t decode_4x4(input logic [3:0] code);
    key_decode_t d;
    d.digit = 4'd0;
    d.op    = OP_NONE;
    d.equal = 1'b0;
    case (code)
      4'd0:  d.digit = 4'd1;
      4'd1:  d.digit = 4'd2;
      4'd2:  d.digit = 4'd3;
      4'd3:  d.op    = OP_ADD;
      4'd4:  d.digit = 4'd4;
      4'd5:  d.digit = 4'd5;
      4'd6:  d.digit = 4'd6;
      4'd7:  d.op    = OP_SUB;
      4'd8:  d.digit = 4'd7;
      4'd9:  d.digit = 4'd8;
      4'd10: d.digit = 4'd9;
      4'd11: d.op    = OP_MUL;
      4'd12: d.digit = 4'd0;
      4'd13: d.equal = 1'b1;
      4'd14: d.op    = OP_NEG;
      4'd15: d.op    = OP_CLR;
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO holding scanned key codes; head is read
// combinationally from registered storage.
module key_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CNTW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNTW'(DEPTH));

  // A pop frees a slot in the same cycle, so push-on-full succeeds with a pop.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign dout = mem[rd_q];

  // NOTE: storage has no reset; emptiness is tracked by count_q, so stale
  // entries are never observable and the array maps to plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= din;
  end

  // NOTE: non-blocking assignments on all state so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scan_buffer.sv
// Matrix keypad scanner with debounce and a key-code FIFO.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan_buffer
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int DEBOUNCE_CYCLES = 12,
  parameter int SCAN_DWELL      = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_CYCLES   = 1000
) (
  input  logic                          clk,
  input  logic                          nRST,
  input  logic [ROWS-1:0]               RowIn,
  output logic [COLS-1:0]               ColOut,
  output logic                          KeyRdy,
  input  logic                          KeyRd,
  output logic [$clog2(ROWS*COLS)-1:0]  KeyCode,
  output logic [3:0]                    keypad_input,
  output logic [2:0]                    operator_input,
  output logic                          equal_input,
  output logic                          Overflow
);

  localparam int CW  = $clog2(ROWS*COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int CLW = $clog2(COLS);
  localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW  = $clog2(SCAN_DWELL + 1);

  localparam logic [DW-1:0]  DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0]  DWELL_LAST = SW'(SCAN_DWELL - 1);
  localparam logic [CLW-1:0] COL_LAST   = CLW'(COLS - 1);

  if (ROWS < 2 || ROWS > 8) begin : g_bad_rows
    $error("ROWS must be in 2..8");
  end
  if (COLS < 2 || COLS > 8) begin : g_bad_cols
    $error("COLS must be in 2..8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be >= 1");
  end

  scan_state_e    state_q, state_d;
  logic [CLW-1:0] col_q, col_d;
  logic [SW-1:0]  dwell_q, dwell_d;
  logic [RW-1:0]  row_q, row_d;
  logic [DW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;

  logic           row_hit;
  logic [RW-1:0]  low_row;
  logic           key_push, push;
  logic [CW-1:0]  push_code, head_code;
  logic           fifo_empty, fifo_full;

  assign ColOut    = ~(COLS'(1) << col_q);
  assign push_code = CW'(int'(row_q) * COLS + int'(col_q));

  // Descending loop so the lowest-index low row wins.
  always_comb begin
    row_hit = ~&RowIn;
    low_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!RowIn[r]) low_row = RW'(r);
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    dwell_d  = dwell_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    key_push = 1'b0;
    unique case (state_q)
      ST_SCAN: begin
        if (row_hit) begin
          row_d   = low_row;
          cnt_d   = '0;
          state_d = ST_DEBOUNCE;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          col_d   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (!RowIn[row_q]) begin
          if (cnt_q == DB_LAST) begin
            cnt_d   = '0;
            state_d = ST_PUSH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          // Bounce: resume scanning on the same column with a fresh dwell.
          cnt_d   = '0;
          dwell_d = '0;
          state_d = ST_SCAN;
        end
      end
      ST_PUSH: begin
        key_push = 1'b1;
        cnt_d    = '0;
        state_d  = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (&RowIn) begin
          if (cnt_q == DB_LAST) begin
            cnt_d   = '0;
            dwell_d = '0;
            state_d = ST_SCAN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RPW = $clog2(REPEAT_CYCLES + 1);

  logic [RPW-1:0] rep_q, rep_d;
  logic           rep_fire;

  // rep_q holds cycles elapsed since the last push of the held key.
  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (state_q == ST_PUSH) begin
      rep_d = RPW'(1);
    end else if (state_q == ST_RELEASE) begin
      if (rep_q == RPW'(REPEAT_CYCLES)) begin
        rep_d    = RPW'(1);
        rep_fire = ~RowIn[row_q];
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) rep_q <= '0;
    else       rep_q <= rep_d;
  end

  assign push = key_push | rep_fire;
`else
  assign push = key_push;
`endif

  // A full buffer only frees a slot if the reader pops in the same cycle.
  assign ovf_d = ovf_q | (push & fifo_full & ~KeyRd);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_SCAN;
      col_q   <= '0;
      dwell_q <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      dwell_q <= dwell_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  key_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nRST  (nRST),
    .push  (push),
    .pop   (KeyRd),
    .din   (push_code),
    .dout  (head_code),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign KeyRdy   = ~fifo_empty;
  assign KeyCode  = fifo_empty ? '0 : head_code;
  assign Overflow = ovf_q;

  if (ROWS == 4 && COLS == 4) begin : g_dec4
    key_decode_t dec;
    always_comb begin
      dec = '0;
      if (!fifo_empty) dec = decode_4x4(4'(head_code));
    end
    assign keypad_input   = dec.digit;
    assign operator_input = dec.op;
    assign equal_input    = dec.equal;
  end else begin : g_dec_none
    assign keypad_input   = 4'd0;
    assign operator_input = 3'd0;
    assign equal_input    = 1'b0;
  end

endmodule

// File: tb/tb_keypad_scan_buffer.sv
// Bench for keypad_scan_buffer: a keypad model drives RowIn from ColOut and
// a queue of expected codes tracks what the buffer should hold.
module tb_keypad_scan_buffer;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DEPTH = 4;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP = 20;
`else
  localparam int REP = 1000;
`endif

  logic       clk = 1'b0;
  logic       nRST = 1'b1;
  logic [3:0] RowIn;
  logic [3:0] ColOut;
  logic       KeyRdy;
  logic       KeyRd = 1'b0;
  logic [3:0] KeyCode;
  logic [3:0] keypad_input;
  logic [2:0] operator_input;
  logic       equal_input;
  logic       Overflow;

  bit key_down = 1'b0;
  int key_r = 0;
  int key_c = 0;

  int n_vec = 0;
  int n_err = 0;
  int model_q[$];
  bit ovf_exp = 1'b0;

  always #5 clk = ~clk;

  // Physical keypad: a held key pulls its row low while its column is driven.
  always_comb begin
    RowIn = '1;
    if (key_down && ColOut[key_c] == 1'b0) RowIn[key_r] = 1'b0;
  end

  keypad_scan_buffer #(
    .ROWS            (ROWS),
    .COLS            (COLS),
    .DEBOUNCE_CYCLES (12),
    .SCAN_DWELL      (4),
    .FIFO_DEPTH      (DEPTH),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk            (clk),
    .nRST           (nRST),
    .RowIn          (RowIn),
    .ColOut         (ColOut),
    .KeyRdy         (KeyRdy),
    .KeyRd          (KeyRd),
    .KeyCode        (KeyCode),
    .keypad_input   (keypad_input),
    .operator_input (operator_input),
    .equal_input    (equal_input),
    .Overflow       (Overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Calculator layout: 3x3 digits 1..9, column 3 add/sub/mul, bottom row 0 = neg clr.
  function automatic void ref_decode(input int code, output int dig, output int op, output int eq);
    int r, c;
    r = code / COLS;
    c = code % COLS;
    dig = 0; op = 0; eq = 0;
    if (r < 3 && c < 3)  dig = r * 3 + c + 1;
    else if (r < 3)      op  = r + 1;
    else if (c == 1)     eq  = 1;
    else if (c >= 2)     op  = c + 2;
  endfunction

  task automatic check_outputs(input string tag);
    int code, dig, op, eq;
    code = 0; dig = 0; op = 0; eq = 0;
    if (model_q.size() > 0) begin
      code = model_q[0];
      ref_decode(code, dig, op, eq);
    end
    check({tag, ".rdy"},  KeyRdy, (model_q.size() > 0) ? 1 : 0);
    check({tag, ".code"}, KeyCode, code);
    check({tag, ".dig"},  keypad_input, dig);
    check({tag, ".op"},   operator_input, op);
    check({tag, ".eq"},   equal_input, eq);
    check({tag, ".ovf"},  Overflow, ovf_exp);
  endtask

  task automatic wait_col(input int c);
    for (int n = 0; n < 40 && ColOut[c] !== 1'b0; n++) @(negedge clk);
    check("col_reach", ColOut[c], 0);
  endtask

  // Hold the key for exactly 13 sampled cycles once its column is driven.
  task automatic press_full(input int r, input int c, input bit pop_in_push);
    key_r = r; key_c = c; key_down = 1'b1;
    wait_col(c);
    repeat (13) @(negedge clk);
    key_down = 1'b0;
    check_outputs("pre_push");
    if (pop_in_push) KeyRd = 1'b1;
    @(negedge clk);
    KeyRd = 1'b0;
    if (pop_in_push && model_q.size() > 0) void'(model_q.pop_front());
    if (model_q.size() < DEPTH) model_q.push_back(r * COLS + c);
    else ovf_exp = 1'b1;
    check_outputs("push");
    repeat (14) @(negedge clk);
    check_outputs("released");
  endtask

  task automatic press_bounce(input int r, input int c, input int b);
    key_r = r; key_c = c; key_down = 1'b1;
    wait_col(c);
    repeat (b) @(negedge clk);
    key_down = 1'b0;
    @(negedge clk);
    check("bounce_col", ColOut[c], 0);
    repeat (2) @(negedge clk);
    check_outputs("bounce");
  endtask

  task automatic pop_one();
    check_outputs("pre_pop");
    KeyRd = 1'b1;
    @(negedge clk);
    KeyRd = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
    check_outputs("post_pop");
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    #2 nRST = 1'b0;
    key_down = 1'b0;
    KeyRd = 1'b0;
    model_q.delete();
    ovf_exp = 1'b0;
    #1;
    check("rst_col", ColOut, 4'b1110);
    check_outputs("rst");
    @(negedge clk);
    nRST = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 nRST = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_col", ColOut, 4'b1110);
    check_outputs("por");
    nRST = 1'b1;

    // Key '1' (row0/col0) decodes to digit 1.
    press_full(0, 0, 1'b0);

    // Short bounce on row0 right after reset: no push, column 0 resumes.
    do_reset();
    press_bounce(0, 0, 5);
    check("bounce_col0", ColOut, 4'b1110);

    // Reset during debounce and during release discards the press.
    key_r = 0; key_c = 2; key_down = 1'b1;
    wait_col(2);
    repeat (6) @(negedge clk);
    do_reset();
    repeat (30) @(negedge clk);
    check_outputs("mid_debounce");
    key_r = 2; key_c = 1; key_down = 1'b1;
    wait_col(1);
    repeat (16) @(negedge clk);
    do_reset();
    repeat (30) @(negedge clk);
    check_outputs("mid_release");

    // Five presses into a four-entry buffer: fifth dropped, overflow sticky.
    press_full(0, 0, 1'b0);
    press_full(0, 1, 1'b0);
    press_full(1, 2, 1'b0);
    press_full(2, 3, 1'b0);
    press_full(3, 1, 1'b0);
    repeat (4) pop_one();

    // Full buffer with a pop in the push cycle: both succeed.
    do_reset();
    press_full(0, 2, 1'b0);
    press_full(1, 0, 1'b0);
    press_full(1, 1, 1'b0);
    press_full(2, 0, 1'b0);
    press_full(3, 3, 1'b1);
    repeat (4) pop_one();

    // Equal key, then a pop on an empty buffer changes nothing.
    do_reset();
    press_full(3, 1, 1'b0);
    pop_one();
    pop_one();
    press_full(3, 2, 1'b0);
    pop_one();

`ifdef KEYPAD_REPEAT_EN
    // Key '5' held 65 cycles past its push: original plus three repeats.
    do_reset();
    key_r = 1; key_c = 1; key_down = 1'b1;
    wait_col(1);
    repeat (13) @(negedge clk);
    check_outputs("rep_pre");
    repeat (65) @(negedge clk);
    key_down = 1'b0;
    repeat (20) @(negedge clk);
    repeat (4) model_q.push_back(5);
    check_outputs("rep_held");
    repeat (4) pop_one();
`endif

    // Randomised mix of full presses, bounces and reads.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      int sel, r, c;
      bit pip;
      sel = $urandom_range(0, 9);
      r = $urandom_range(0, ROWS - 1);
      c = $urandom_range(0, COLS - 1);
      if (sel <= 5) begin
        pip = (model_q.size() == DEPTH) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
        press_full(r, c, pip);
      end else if (sel <= 7) begin
        press_bounce(r, c, $urandom_range(1, 12));
      end else begin
        repeat ($urandom_range(1, 2)) pop_one();
      end
    end
    while (model_q.size() > 0) pop_one();
    pop_one();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
